beep_scheduler: RTL

- Shares one buzzer between NUM_REQ debounced key inputs.
- Each falling edge on a key latches a pending request. A round-robin arbiter grants one request at a time.
- The granted request plays a beep burst: requester index i produces i+1 beeps.
- Sits between the key debounce filters and the board buzzer pin. It replaces direct key-to-beep toggling once more than one key must sound.

---
 rtl/beep_sched_pkg.sv | 22 ++
 rtl/beep_scheduler_rr_arbiter.sv | 52 +++++
 rtl/beep_scheduler.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/beep_sched_pkg.sv
// beep_sched_pkg: shared FSM encoding, default timing and width helper for
// the beep scheduler. Optional build macro: BEEP_SCHED_PRIO_EN (see rr_arbiter).
package beep_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

  localparam int DEF_ON_CYC  = 5_000_000;
  localparam int DEF_OFF_CYC = 5_000_000;
  localparam int DEF_GAP_CYC = 10_000_000;
  localparam int DEF_CNT_W   = 24;

  // Bits needed to index num_req requesters (at least one bit).
  function automatic int idx_width(input int num_req);
    return (num_req <= 1) ? 1 : $clog2(num_req);
  endfunction

endpackage

// File: rtl/beep_scheduler_rr_arbiter.sv
// rr_arbiter: combinational request picker for the beep scheduler.
// Default: round-robin search starting at rr_ptr with wrap-around.
// With BEEP_SCHED_PRIO_EN defined: fixed priority, lowest pending index wins,
// and the rr_ptr input does not exist.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
`ifndef BEEP_SCHED_PRIO_EN
  input  logic [IDX_W-1:0]   rr_ptr,
`endif
  input  logic [NUM_REQ-1:0] pend,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx
);

`ifdef BEEP_SCHED_PRIO_EN
  // Lowest set pend bit wins; scanning downward lets the lowest overwrite.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (pend[k]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(k);
      end
    end
  end
`else
  localparam int SW = IDX_W + 1;

  logic [SW-1:0] w_sum;

  // Walk upward from rr_ptr, wrapping at NUM_REQ; first pending bit wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    w_sum       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, rr_ptr} + SW'(k);
      if (w_sum >= SW'(NUM_REQ)) begin
        w_sum = w_sum - SW'(NUM_REQ);
      end
      if (!grant_valid && pend[w_sum[IDX_W-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = w_sum[IDX_W-1:0];
      end
    end
  end
`endif

endmodule

// File: rtl/beep_scheduler.sv
// beep_scheduler: shares one active-low buzzer among NUM_REQ active-low keys.
// A falling key edge latches a pending request; the arbiter grants one at a
// time and requester i plays i+1 beeps followed by a silent gap.
// Optional build macro: BEEP_SCHED_PRIO_EN (fixed priority, no rr pointer).
//
// Timing contract: the grant edge starts the burst (busy rises, beep falls);
// beep is low ON_CYC cycles per beep, high OFF_CYC cycles between beeps, then
// GAP_CYC silent cycles, after which done pulses for one cycle in IDLE.
module beep_scheduler
  import beep_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ON_CYC  = DEF_ON_CYC,
  parameter int OFF_CYC = DEF_OFF_CYC,
  parameter int GAP_CYC = DEF_GAP_CYC,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic [NUM_REQ-1:0] key_filter,
  output logic               beep,
  output logic               busy,
  output logic [2:0]         grant_id,
  output logic [NUM_REQ-1:0] pend,
  output logic               done,
  output logic [1:0]         dbg_state
);

  localparam int IDX_W = idx_width(NUM_REQ);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [NUM_REQ-1:0] r_key_d;
  logic               r_key_vld;
  logic [NUM_REQ-1:0] r_pend;
  logic [CNT_W-1:0]   r_cnt;
  logic [3:0]         r_beep_left;
  logic [2:0]         r_grant_id;
  logic               r_done;

  logic [NUM_REQ-1:0] w_event;
  logic [NUM_REQ-1:0] w_take;
  logic               w_grant_valid;
  logic [IDX_W-1:0]   w_grant_idx;
  logic               w_cnt_end;
  logic               w_grant;

  // key_d resets to all ones, so the first sampled cycle after reset is
  // masked by r_key_vld: a key already held low at release is not a press.
  assign w_event = r_key_vld ? (r_key_d & ~key_filter) : '0;
  assign w_grant = (r_state == ST_IDLE) && w_grant_valid;
  assign w_take  = w_grant ? (NUM_REQ'(1) << w_grant_idx) : '0;

`ifdef BEEP_SCHED_PRIO_EN
  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .pend        (r_pend),
    .grant_valid (w_grant_valid),
    .grant_idx   (w_grant_idx)
  );
`else
  logic [IDX_W-1:0] r_rr_ptr;

  // Round-robin pointer moves just past the most recent grant.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_rr_ptr <= '0;
    end else if (w_grant) begin
      r_rr_ptr <= (w_grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + IDX_W'(1);
    end
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .rr_ptr      (r_rr_ptr),
    .pend        (r_pend),
    .grant_valid (w_grant_valid),
    .grant_idx   (w_grant_idx)
  );
`endif

  // Terminal count for the duration of the current state.
  always_comb begin
    w_cnt_end = 1'b0;
    case (r_state)
      ST_ON:   w_cnt_end = (r_cnt == CNT_W'(ON_CYC - 1));
      ST_OFF:  w_cnt_end = (r_cnt == CNT_W'(OFF_CYC - 1));
      ST_GAP:  w_cnt_end = (r_cnt == CNT_W'(GAP_CYC - 1));
      default: w_cnt_end = 1'b0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_grant_valid) w_state_nxt = ST_ON;
      ST_ON:   if (w_cnt_end) w_state_nxt = (r_beep_left == 4'd1) ? ST_GAP : ST_OFF;
      ST_OFF:  if (w_cnt_end) w_state_nxt = ST_ON;
      ST_GAP:  if (w_cnt_end) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: key history, pending bitmap, duration counter, beep count, done.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_key_d     <= '1;
      r_key_vld   <= 1'b0;
      r_pend      <= '0;
      r_cnt       <= '0;
      r_beep_left <= '0;
      r_grant_id  <= '0;
      r_done      <= 1'b0;
    end else begin
      r_key_d   <= key_filter;
      r_key_vld <= 1'b1;
      // A new event on the just-granted bit re-arms it.
      r_pend    <= (r_pend & ~w_take) | w_event;
      r_done    <= (r_state == ST_GAP) && w_cnt_end;
      case (r_state)
        ST_IDLE: begin
          if (w_grant_valid) begin
            r_grant_id  <= 3'(w_grant_idx);
            r_beep_left <= 4'(w_grant_idx) + 4'd1;
            r_cnt       <= '0;
          end
        end
        ST_ON: begin
          if (w_cnt_end) begin
            r_cnt       <= '0;
            r_beep_left <= r_beep_left - 4'd1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          if (w_cnt_end) r_cnt <= '0;
          else           r_cnt <= r_cnt + CNT_W'(1);
        end
      endcase
    end
  end

  // FSM outputs: beep sounds only in ON, busy covers ON/OFF/GAP.
  always_comb begin
    beep      = (r_state != ST_ON);
    busy      = (r_state != ST_IDLE);
    grant_id  = r_grant_id;
    pend      = r_pend;
    done      = r_done;
    dbg_state = r_state;
  end

endmodule
